// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: key codes, FSM/frame encodings and the (row,col) to code map.
// Used by keypad_scanner, keypad_debounce and the downstream control FSM.
package keypad_scanner_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 3;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CODE_W-1:0] KEY_0      = 4'd0;
    localparam logic [CODE_W-1:0] KEY_1      = 4'd1;
    localparam logic [CODE_W-1:0] KEY_2      = 4'd2;
    localparam logic [CODE_W-1:0] KEY_3      = 4'd3;
    localparam logic [CODE_W-1:0] KEY_4      = 4'd4;
    localparam logic [CODE_W-1:0] KEY_5      = 4'd5;
    localparam logic [CODE_W-1:0] KEY_6      = 4'd6;
    localparam logic [CODE_W-1:0] KEY_7      = 4'd7;
    localparam logic [CODE_W-1:0] KEY_8      = 4'd8;
    localparam logic [CODE_W-1:0] KEY_9      = 4'd9;
    localparam logic [CODE_W-1:0] KEY_START  = 4'd10;
    localparam logic [CODE_W-1:0] KEY_CANCEL = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_kind_e;

    typedef struct packed {
        frame_kind_e         kind;
        logic [CODE_W-1:0]   code;
    } frame_t;

    // Rows 0..2 carry the digits 1..9; row 3 is '*', '0', '#'.
    function automatic logic [CODE_W-1:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [CODE_W-1:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_START;
                2'd1:    code = KEY_0;
                default: code = KEY_CANCEL;
            endcase
        end else begin
            code = CODE_W'(32'(row) * 32'd3 + 32'(col) + 32'd1);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: accepts a single stable key, waits for full release.
// Build macro KEYPAD_AUTOREPEAT_EN enables repeat pulses while the key stays held.
module keypad_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT  = 4,
    parameter int unsigned REPEAT_FRAMES = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    input  frame_t            frame,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    kp_state_e         state, state_d;
    logic [CODE_W-1:0] cand, cand_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CNT_W-1:0]  rel, rel_d;
    logic              accept_c, release_c, repeat_c;
    logic [CODE_W-1:0] key_code_d;
    logic              key_valid_d, key_held_d;
    logic              single_c;

    assign single_c = (frame.kind == FR_SINGLE);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES + 1) : 1;
    logic [RPT_W-1:0] rpt, rpt_d;
`else
    logic unused_repeat;
    assign unused_repeat = ^32'(REPEAT_FRAMES);
`endif

    // State, counter and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cand      <= '0;
            cnt       <= '0;
            rel       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt       <= '0;
`endif
        end else begin
            state     <= state_d;
            cand      <= cand_d;
            cnt       <= cnt_d;
            rel       <= rel_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt       <= rpt_d;
`endif
        end
    end

    // Next-state: only acts on the frame evaluation strobe.
    always_comb begin
        state_d   = state;
        cand_d    = cand;
        cnt_d     = cnt;
        rel_d     = rel;
        accept_c  = 1'b0;
        release_c = 1'b0;
        repeat_c  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d     = rpt;
`endif
        if (frame_valid) begin
            case (state)
                ST_IDLE: begin
                    if (single_c) begin
                        cand_d = frame.code;
                        if (DEBOUNCE_CNT <= 1) begin
                            accept_c = 1'b1;
                            state_d  = ST_PRESSED;
                            cnt_d    = '0;
                            rel_d    = '0;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (single_c && (frame.code == cand)) begin
                        if ((cnt + CNT_W'(1)) == CNT_W'(DEBOUNCE_CNT)) begin
                            accept_c = 1'b1;
                            state_d  = ST_PRESSED;
                            cnt_d    = '0;
                            rel_d    = '0;
                        end else begin
                            cnt_d = cnt + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (frame.kind == FR_NONE) begin
                        if ((rel + CNT_W'(1)) == CNT_W'(DEBOUNCE_CNT)) begin
                            release_c = 1'b1;
                            state_d   = ST_IDLE;
                            rel_d     = '0;
                        end else begin
                            rel_d = rel + CNT_W'(1);
                        end
                    end else begin
                        rel_d = '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (single_c && (frame.code == cand)) begin
                        if ((rpt + RPT_W'(1)) == RPT_W'(REPEAT_FRAMES)) begin
                            repeat_c = 1'b1;
                            rpt_d    = '0;
                        end else begin
                            rpt_d = rpt + RPT_W'(1);
                        end
                    end else begin
                        rpt_d = '0;
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rel_d   = '0;
                end
            endcase
`ifdef KEYPAD_AUTOREPEAT_EN
            if (accept_c) begin
                rpt_d = '0;
            end
`endif
        end
    end

    // Output next values; key_valid is a one-cycle pulse after the evaluation edge.
    always_comb begin
        key_code_d  = key_code;
        key_valid_d = 1'b0;
        key_held_d  = key_held;
        if (accept_c) begin
            key_code_d  = cand_d;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
        end
        if (repeat_c) begin
            key_valid_d = 1'b1;
        end
        if (release_c) begin
            key_held_d = 1'b0;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row synchronizer, frame classification.
// Build macro KEYPAD_AUTOREPEAT_EN adds held-key repeat pulses in keypad_debounce.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV      = 1000,
    parameter int unsigned DEBOUNCE_CNT  = 4,
    parameter int unsigned REPEAT_FRAMES = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ROWS-1:0]     row_in,
    output logic [COLS-1:0]     col_out,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0]           div_cnt;
    logic [1:0]                 col_idx;
    logic [ROWS-1:0]            row_meta, row_sync;
    logic [ROWS-1:0]            samp0, samp1;
    logic                       col_last_c;
    logic                       frame_valid_c;
    logic [COLS-1:0][ROWS-1:0]  frame_rows_c;
    logic [3:0]                 hits_c;
    frame_t                     frame_c;

    // Two-flop synchronizer; idle rows read high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign col_last_c    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_valid_c = col_last_c && (col_idx == 2'd2);

    // Divider and column walk; rows are captured on the last count of each column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
            col_out <= 3'b110;
            samp0   <= '1;
            samp1   <= '1;
        end else if (col_last_c) begin
            div_cnt <= '0;
            case (col_idx)
                2'd0: begin
                    samp0   <= row_sync;
                    col_idx <= 2'd1;
                    col_out <= 3'b101;
                end
                2'd1: begin
                    samp1   <= row_sync;
                    col_idx <= 2'd2;
                    col_out <= 3'b011;
                end
                default: begin
                    col_idx <= 2'd0;
                    col_out <= 3'b110;
                end
            endcase
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Column 2 is not stored: it is classified straight from the live synchronized rows.
    assign frame_rows_c = {row_sync, samp1, samp0};

    always_comb begin
        hits_c       = '0;
        frame_c.code = '0;
        frame_c.kind = FR_NONE;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (!frame_rows_c[c][r]) begin
                    hits_c       = hits_c + 4'd1;
                    frame_c.code = key_map(2'(r), 2'(c));
                end
            end
        end
        if (hits_c == 4'd1) begin
            frame_c.kind = FR_SINGLE;
        end else if (hits_c != 4'd0) begin
            frame_c.kind = FR_MULTI;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_CNT  (DEBOUNCE_CNT),
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid_c),
        .frame       (frame_c),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 (12-cycle frames).
// Cycle numbers count clock edges since the last reset release; frame f is evaluated at edge 12f.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV      = 4;
    localparam int unsigned DEBOUNCE_CNT  = 3;
    localparam int unsigned REPEAT_FRAMES = 5;

    localparam int K1 = 0, K3 = 2, K5 = 4, K7 = 6, K9 = 8, K0 = 10, KHASH = 11;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [2:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [11:0] keys;
    int          cyc;
    int          pulses;
    int          pulse_cyc;
    int          pulse_code;
    int          p0;
    int          checks;
    int          failures;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_CNT  (DEBOUNCE_CNT),
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a closed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keys[r*3 + c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulses     = pulses + 1;
            pulse_cyc  = cyc;
            pulse_code = int'(key_code);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) begin
            failures++;
            $error("FAIL goto: observed cycle %0d expected %0d", cyc, t);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        pulses     = 0;
        pulse_cyc  = -1;
        pulse_code = -1;
        keys       = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_col_out",   32'(col_out),   32'b110);
        check("rst_key_code",  32'(key_code),  0);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_key_held",  32'(key_held),  0);

        // Key 5 held through reset release: accepted at frame 3.
        keys[K5] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        goto(35);
        check("t1_no_early_pulse", 32'(pulses), 0);
        check("t1_no_early_held",  32'(key_held), 0);
        goto(36);
        check("t1_valid",      32'(key_valid), 1);
        check("t1_code",       32'(key_code),  5);
        check("t1_held",       32'(key_held),  1);
        goto(37);
        check("t1_valid_drop", 32'(key_valid), 0);

        // Asynchronous reset mid-scan with the key pressed.
        goto(54);
        check("t1_col_before_rst",  32'(col_out),  32'b101);
        check("t1_held_before_rst", 32'(key_held), 1);
        rst_n = 1'b0;
        #1;
        check("t1_async_col",   32'(col_out),   32'b110);
        check("t1_async_code",  32'(key_code),  0);
        check("t1_async_held",  32'(key_held),  0);
        check("t1_async_valid", 32'(key_valid), 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        goto(35);
        check("t1_exit_no_pulse", 32'(pulses - p0), 0);
        goto(36);
        check("t2_valid", 32'(key_valid), 1);
        check("t2_code",  32'(key_code),  5);
        goto(37);
        check("t2_pulse_cyc", 32'(pulse_cyc), 36);

        // Hold to frame 10, then release: held drops after 3 empty frames.
        goto(120);
        check("t2_single_pulse", 32'(pulses - p0), 1);
        check("t2_held_on",      32'(key_held), 1);
        keys = '0;
        goto(155);
        check("t2_held_before_rel", 32'(key_held), 1);
        goto(156);
        check("t2_held_off",   32'(key_held), 0);
        check("t2_code_holds", 32'(key_code), 5);

        // Bounce on '#': 2 frames present, 1 absent, 3 present.
        keys[KHASH] = 1'b1;
        p0 = pulses;
        goto(180);
        keys = '0;
        goto(192);
        keys[KHASH] = 1'b1;
        goto(227);
        check("t3_no_early_pulse", 32'(pulses - p0), 0);
        goto(228);
        check("t3_valid", 32'(key_valid), 1);
        check("t3_code",  32'(key_code),  11);
        keys = '0;
        goto(264);
        check("t3_one_pulse", 32'(pulses - p0), 1);
        check("t3_released",  32'(key_held), 0);

        // Keys 1 and 9 together for 8 frames: never accepted.
        keys[K1] = 1'b1;
        keys[K9] = 1'b1;
        p0 = pulses;
        goto(360);
        check("t4_no_pulse", 32'(pulses - p0), 0);
        check("t4_not_held", 32'(key_held), 0);
        check("t4_code",     32'(key_code), 11);
        keys = '0;

        // Rollover: hold 0, add 7, drop 0 keeping 7, then release all.
        keys[K0] = 1'b1;
        goto(396);
        check("t5_valid", 32'(key_valid), 1);
        check("t5_code",  32'(key_code),  0);
        check("t5_held",  32'(key_held),  1);
        keys[K7] = 1'b1;
        goto(420);
        keys[K0] = 1'b0;
        goto(492);
        check("t5_held_with_7", 32'(key_held), 1);
        check("t5_one_pulse",   32'(pulses - p0), 1);
        keys = '0;
        goto(527);
        check("t5_held_before_rel", 32'(key_held), 1);
        goto(528);
        check("t5_held_off", 32'(key_held), 0);
        check("t5_code",     32'(key_code), 0);
        check("t5_last_pulse_code", 32'(pulse_code), 0);

        // Hold 3 for 20 frames.
        keys[K3] = 1'b1;
        p0 = pulses;
        goto(564);
        check("t6_valid", 32'(key_valid), 1);
        check("t6_code",  32'(key_code),  3);
`ifdef KEYPAD_AUTOREPEAT_EN
        goto(623);
        check("t6_no_early_repeat", 32'(key_valid), 0);
        goto(624);
        check("t6_rep1_valid", 32'(key_valid), 1);
        check("t6_rep1_code",  32'(key_code),  3);
        goto(625);
        check("t6_rep1_drop",  32'(key_valid), 0);
        goto(684);
        check("t6_rep2_valid", 32'(key_valid), 1);
        goto(744);
        check("t6_rep3_valid", 32'(key_valid), 1);
        check("t6_rep3_code",  32'(key_code),  3);
        goto(768);
        check("t6_pulse_count", 32'(pulses - p0), 4);
`else
        goto(768);
        check("t6_pulse_count", 32'(pulses - p0), 1);
`endif
        keys = '0;
        goto(804);
        check("t6_released", 32'(key_held), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
